pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a WIDTH-bit payload with valid/ready handshake, synchronous flush to a bubble value and a
//  saturating stall-cycle counter. Replaces fixed-width load-enable stage registers; one instance per boundary.
// PARAMETERS
//  WIDTH   115  payload width in bits (115 = ID/EX bundle)
//  CNT_W   16   width of stall_cnt
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset      in   1      synchronous, active-low
//  flush      in   1      kill contents; load bubble value (hazard/branch squash)
//  bubble     in   WIDTH  payload loaded on reset and flush (NOP encoding)
//  in_valid   in   1      upstream beat present
//  in_ready   out  1      stage can accept a beat this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data holds a live beat
//  out_ready  in   1      downstream accepts this cycle
//  out_data   out  WIDTH  registered payload
//  stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - Transfer on a port occurs in a cycle where valid && ready are both 1 at posedge.
//  - reset=0 at posedge: out_valid=0, out_data=bubble, stall_cnt=0, skid (if built) empty, skid data=bubble.
//    Reset beats flush and every other input. in_ready reads 0 while reset=0.
//  - flush=1 at posedge (reset=1): out_valid=0, out_data=bubble, skid emptied; in_ready=0 during flush cycle,
//    so the offered input beat is NOT consumed; stall_cnt unchanged. Flush beats simultaneous load.
//  - Normal (no skid): in_ready = !out_valid || out_ready (combinational from out_ready).
//    Accept: out_data<=in_data, out_valid<=1, one-cycle latency. Drain without new beat: out_valid<=0,
//    out_data held. Simultaneous drain+accept: new beat replaces old same edge, out_valid stays 1.
//  - out_valid=1 && out_ready=0: out_data/out_valid held stable (no change until accepted or flushed).
//  - stall_cnt: +1 each posedge with out_valid=1 && out_ready=0 && flush=0 && reset=1; sticks at 2^CNT_W-1.
//  - No combinational path in_data->out_data; out_data always a flop output.
//  - Bubble value sampled at the reset/flush edge only; later changes to bubble do not alter out_data.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: adds one-entry skid buffer (skid_data, skid_valid).
//   - in_ready = !skid_valid (registered; no comb path from out_ready). Latency still one cycle when not stalled.
//   - Beat accepted while out_valid=1 && out_ready=0 goes to skid; next drain moves skid->out, skid_valid<=0.
//   - Full (out and skid valid): in_ready=0. Order strictly preserved, no beat dropped or duplicated.
//   - Flush empties both entries.
//  Not defined: skid logic absent; in_ready as in Normal rule above; max 1 beat in flight.
// TESTING
//  1 reset: bubble=0x0AA, reset=0 for 2 clks with in_valid=1 -> out_valid=0, out_data=0x0AA, stall_cnt=0, in_ready=0.
//  2 stream: out_ready=1, in beats 1,2,3 back-to-back -> out_data 1,2,3 one cycle later each, no gaps.
//  3 stall: hold beat 5, out_ready=0 for 4 clks -> out_data=5 stable, stall_cnt=4; release -> 5 accepted once.
//  4 flush: out_valid=1 data=7, flush=1 with in_valid=1 data=8 -> next cycle out_valid=0, out_data=bubble,
//    beat 8 not accepted (in_ready=0), stall_cnt unchanged.
//  5 saturate: CNT_W=3, stall 10 clks -> stall_cnt=7 and holds.
//  6 skid (PIPE_STAGE_SKID_EN): out_ready=0, offer 1,2,3 -> 1 in out, 2 in skid, in_ready=0, 3 held upstream;
//    out_ready=1 -> outputs 1,2,3 in order, none lost or repeated.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Handshake bundle for one pipeline-stage boundary: upstream beat in, registered beat out.
// master = the stage register itself, slave = the surrounding pipeline.
interface pipe_stage_if #(
  parameter int WIDTH = 115
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, flush-to-bubble and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer (registered in_ready, two beats in flight).
module pipe_stage_reg #(
  parameter int WIDTH = 115,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] bubble,
  pipe_stage_if.master     bus,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;
  logic             stalled_s;

  assign accept_s  = bus.in_valid & in_ready_s;
  assign drain_s   = out_valid_r & bus.out_ready;
  assign stalled_s = out_valid_r & ~bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid_r;
  logic [WIDTH-1:0] skid_data_r;

  // Ready depends only on skid occupancy, breaking the out_ready -> in_ready timing path.
  always_comb begin
    in_ready_s = 1'b0;
    if (reset && !flush) begin
      in_ready_s = ~skid_valid_r;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // Output and skid entries; skid only fills while the output is stalled, so order is preserved.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= bubble;
      skid_valid_r <= 1'b0;
      skid_data_r  <= bubble;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= bubble;
      skid_valid_r <= 1'b0;
      skid_data_r  <= bubble;
    end else if (!out_valid_r) begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.in_data;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (drain_s) begin
      if (skid_valid_r) begin
        out_data_r   <= skid_data_r;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        out_data_r <= bus.in_data;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_r <= 1'b1;
        skid_data_r  <= bus.in_data;
      end else begin
        skid_valid_r <= skid_valid_r;
      end
    end
  end
`else
  // A single entry can take a new beat when empty or when its current beat leaves this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (reset && !flush) begin
      in_ready_s = ~out_valid_r | bus.out_ready;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // Output entry: load on accept, go empty on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= bubble;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      out_data_r  <= bubble;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= bus.in_data;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end
`endif

  // Stall cycle counter; frozen during flush and saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      stall_cnt_r <= stall_cnt_r;
    end else if (stalled_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, stall, flush, counter saturation, and skid ordering.
module tb_pipe_stage_reg;
  localparam int WIDTH = 115;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] bubble;
  logic [CNT_W-1:0] stall_cnt;
  int               n_chk;
  int               n_fail;

  pipe_stage_if #(.WIDTH(WIDTH)) bus ();

  pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bubble    (bubble),
    .bus       (bus.master),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    reset        = 1'b0;
    flush        = 1'b0;
    bubble       = 115'h0AA;
    bus.in_valid = 1'b1;
    bus.in_data  = 115'h55;
    bus.out_ready = 1'b0;

    // 1: reset dominates an offered beat
    tick();
    tick();
    chk("rst_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_data", {13'd0, bus.out_data}, 128'h0AA);
    chk("rst_cnt", {125'd0, stall_cnt}, 128'd0);
    chk("rst_ready", {127'd0, bus.in_ready}, 128'd0);

    // 2: back-to-back stream, one-cycle latency
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data = 115'd1;
    #1;
    chk("str_ready", {127'd0, bus.in_ready}, 128'd1);
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 115'(i);
      tick();
      chk($sformatf("str_valid%0d", i), {127'd0, bus.out_valid}, 128'd1);
      chk($sformatf("str_data%0d", i), {13'd0, bus.out_data}, 128'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("str_empty", {127'd0, bus.out_valid}, 128'd0);
    chk("str_hold", {13'd0, bus.out_data}, 128'd3);
    chk("str_cnt", {125'd0, stall_cnt}, 128'd0);

    // 3: stall beat 5 for four cycles, then release
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 115'd5;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data = 115'd9;
    chk("stl_load", {13'd0, bus.out_data}, 128'd5);
    chk("stl_cnt0", {125'd0, stall_cnt}, 128'd0);
`ifndef PIPE_STAGE_SKID_EN
    chk("stl_ready", {127'd0, bus.in_ready}, 128'd0);
`endif
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("stl_data%0d", i), {13'd0, bus.out_data}, 128'd5);
      chk($sformatf("stl_valid%0d", i), {127'd0, bus.out_valid}, 128'd1);
    end
    chk("stl_cnt4", {125'd0, stall_cnt}, 128'd4);
    bus.out_ready = 1'b1;
    tick();
    chk("stl_drain", {127'd0, bus.out_valid}, 128'd0);
    chk("stl_cnt_hold", {125'd0, stall_cnt}, 128'd4);
    tick();
    chk("stl_once", {127'd0, bus.out_valid}, 128'd0);

    // 4: flush squashes beat 7 and refuses beat 8
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 115'd7;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("fl_pre_cnt", {125'd0, stall_cnt}, 128'd1);
    bubble = 115'h0BB;
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 115'd8;
    #1;
    chk("fl_ready", {127'd0, bus.in_ready}, 128'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bubble = 115'h0CC;
    chk("fl_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("fl_data", {13'd0, bus.out_data}, 128'h0BB);
    chk("fl_cnt", {125'd0, stall_cnt}, 128'd1);
    tick();
    chk("fl_no8", {127'd0, bus.out_valid}, 128'd0);
    chk("fl_bubble_hold", {13'd0, bus.out_data}, 128'h0BB);

    // 5: counter saturates at 7
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data = 115'h11;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) chk("sat_at7", {125'd0, stall_cnt}, 128'd7);
    end
    chk("sat_cnt", {125'd0, stall_cnt}, 128'd7);
    tick();
    chk("sat_hold", {125'd0, stall_cnt}, 128'd7);
    chk("sat_data", {13'd0, bus.out_data}, 128'h11);

`ifdef PIPE_STAGE_SKID_EN
    // 6: skid holds beat 2 behind stalled beat 1; order 1,2,3 on release
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 115'd1;
    tick();
    bus.in_data = 115'd2;
    chk("sk_ready1", {127'd0, bus.in_ready}, 128'd1);
    tick();
    bus.in_data = 115'd3;
    chk("sk_out1", {13'd0, bus.out_data}, 128'd1);
    chk("sk_full", {127'd0, bus.in_ready}, 128'd0);
    tick();
    chk("sk_still1", {13'd0, bus.out_data}, 128'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("sk_out2", {13'd0, bus.out_data}, 128'd2);
    chk("sk_valid2", {127'd0, bus.out_valid}, 128'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("sk_out3", {13'd0, bus.out_data}, 128'd3);
    chk("sk_valid3", {127'd0, bus.out_valid}, 128'd1);
    tick();
    chk("sk_empty", {127'd0, bus.out_valid}, 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
